anabellek_hakem: RTL

- Arbitrates the single main-memory (iomem) port between the instruction-cache controller (l1b, read-only) and the data-cache controller (l1v, read/write).
- Round-robin grant; one transaction in flight at a time.
- Request fields are latched into registered iomem outputs; completion is returned to the granted requester.
- A watchdog terminates transactions the memory never acknowledges and reports them.

---
 rtl/anabellek_hakem.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/anabellek_hakem.sv
// ---------------------------------------------------------------------------
// anabellek_hakem
//   Round-robin arbiter for the single main-memory (iomem) port, shared by
//   the instruction-cache controller (l1b, read-only) and the data-cache
//   controller (l1v, read/write). Only one transaction is in flight at a
//   time. A watchdog terminates transactions that the memory never
//   acknowledges and reports the address of the terminated transaction.
//
// Handshake: a requester raises *_mem_valid_i with its address (and write
//   data/strobes for l1v) and holds them until it sees *_mem_ready_o high
//   for one cycle. On that cycle *_mem_rdata_o carries the read data. On the
//   memory side iomem_valid_o is held high with stable fields until the cycle
//   where iomem_ready_i is high; the port returns to idle on the next edge.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   l1b_mem_valid_i/addr_i     instruction-cache read request
//   l1b_mem_rdata_o/ready_o    instruction-cache completion
//   l1v_mem_valid_i/addr_i/
//   l1v_mem_wdata_i/wstrb_i    data-cache request (wstrb == 0 means read)
//   l1v_mem_rdata_o/ready_o    data-cache completion
//   iomem_valid_o/addr_o/
//   iomem_wdata_o/wstrb_o      registered request to main memory
//   iomem_rdata_i/ready_i      main-memory response
//   hata_o                     one-cycle pulse on watchdog termination
//   hata_adr_o                 address of the last terminated transaction
// ---------------------------------------------------------------------------
module anabellek_hakem #(
    parameter int unsigned ZAMAN_ASIMI = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        l1b_mem_valid_i,
    input  logic [18:2] l1b_mem_addr_i,
    output logic [31:0] l1b_mem_rdata_o,
    output logic        l1b_mem_ready_o,

    input  logic        l1v_mem_valid_i,
    input  logic [18:2] l1v_mem_addr_i,
    input  logic [31:0] l1v_mem_wdata_i,
    input  logic [3:0]  l1v_mem_wstrb_i,
    output logic [31:0] l1v_mem_rdata_o,
    output logic        l1v_mem_ready_o,

    output logic        iomem_valid_o,
    output logic [18:2] iomem_addr_o,
    output logic [31:0] iomem_wdata_o,
    output logic [3:0]  iomem_wstrb_o,
    input  logic [31:0] iomem_rdata_i,
    input  logic        iomem_ready_i,

    output logic        hata_o,
    output logic [16:0] hata_adr_o
);

    typedef enum logic [1:0] {
        BOSTA         = 2'b00,
        BUYRUK_HIZMET = 2'b01,
        VERI_HIZMET   = 2'b10
    } durum_e;

    // A zero-width counter is illegal, so the disabled watchdog keeps one
    // inert bit that never leaves zero.
    localparam bit          WD_EN = (ZAMAN_ASIMI > 0);
    localparam int unsigned CW    = WD_EN ? $clog2(ZAMAN_ASIMI + 1) : 1;
    localparam logic [CW-1:0] SAYAC_SON = CW'(WD_EN ? ZAMAN_ASIMI - 1 : 0);

    durum_e        state_q, state_d;
    logic          iomem_valid_q, iomem_valid_d;
    logic [18:2]   iomem_addr_q, iomem_addr_d;
    logic [31:0]   iomem_wdata_q, iomem_wdata_d;
    logic [3:0]    iomem_wstrb_q, iomem_wstrb_d;
    logic [16:0]   hata_adr_q, hata_adr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Last served requester: 1 = l1b (instruction), 0 = l1v (data).
    logic          son_q, son_d;

    logic in_service;
    logic expire;
    logic done;
    logic grant_l1b;
    logic grant_l1v;

    // On a tie the requester that was not served last wins.
    assign grant_l1v  = l1v_mem_valid_i && (!l1b_mem_valid_i || son_q);
    assign grant_l1b  = l1b_mem_valid_i && (!l1v_mem_valid_i || !son_q);

    assign in_service = (state_q != BOSTA);
    // A memory acknowledge in the expiry cycle wins over the watchdog.
    assign expire     = WD_EN && in_service && !iomem_ready_i && (cnt_q == SAYAC_SON);
    assign done       = in_service && (iomem_ready_i || expire);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOSTA;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOSTA: begin
                if (grant_l1v) begin
                    state_d = VERI_HIZMET;
                end else if (grant_l1b) begin
                    state_d = BUYRUK_HIZMET;
                end
            end
            BUYRUK_HIZMET, VERI_HIZMET: begin
                if (done) begin
                    state_d = BOSTA;
                end
            end
            default: state_d = BOSTA;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        l1b_mem_ready_o = (state_q == BUYRUK_HIZMET) && done;
        l1v_mem_ready_o = (state_q == VERI_HIZMET) && done;
        // A watchdog termination returns zero data instead of whatever is
        // floating on the memory bus.
        l1b_mem_rdata_o = expire ? 32'h0 : iomem_rdata_i;
        l1v_mem_rdata_o = expire ? 32'h0 : iomem_rdata_i;
        hata_o          = expire;
        iomem_valid_o   = iomem_valid_q;
        iomem_addr_o    = iomem_addr_q;
        iomem_wdata_o   = iomem_wdata_q;
        iomem_wstrb_o   = iomem_wstrb_q;
        hata_adr_o      = hata_adr_q;
    end

    // -----------------------------------------------------------------------
    // Datapath next values: request capture, watchdog, completion bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        iomem_valid_d = iomem_valid_q;
        iomem_addr_d  = iomem_addr_q;
        iomem_wdata_d = iomem_wdata_q;
        iomem_wstrb_d = iomem_wstrb_q;
        hata_adr_d    = hata_adr_q;
        cnt_d         = cnt_q;
        son_d         = son_q;

        if (state_q == BOSTA) begin
            cnt_d = '0;
            if (grant_l1v) begin
                iomem_valid_d = 1'b1;
                iomem_addr_d  = l1v_mem_addr_i;
                iomem_wdata_d = l1v_mem_wdata_i;
                iomem_wstrb_d = l1v_mem_wstrb_i;
            end else if (grant_l1b) begin
                iomem_valid_d = 1'b1;
                iomem_addr_d  = l1b_mem_addr_i;
                iomem_wdata_d = 32'h0;
                iomem_wstrb_d = 4'h0;
            end
        end else if (done) begin
            iomem_valid_d = 1'b0;
            son_d         = (state_q == BUYRUK_HIZMET);
            cnt_d         = '0;
            if (expire) begin
                hata_adr_d = iomem_addr_q;
            end
        end else if (WD_EN) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iomem_valid_q <= 1'b0;
            iomem_addr_q  <= '0;
            iomem_wdata_q <= '0;
            iomem_wstrb_q <= '0;
            hata_adr_q    <= '0;
            cnt_q         <= '0;
            son_q         <= 1'b1;
        end else begin
            iomem_valid_q <= iomem_valid_d;
            iomem_addr_q  <= iomem_addr_d;
            iomem_wdata_q <= iomem_wdata_d;
            iomem_wstrb_q <= iomem_wstrb_d;
            hata_adr_q    <= hata_adr_d;
            cnt_q         <= cnt_d;
            son_q         <= son_d;
        end
    end

endmodule
